// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: turns a length-prefixed big-endian byte
// stream into consecutive word writes starting at address 0, holding the core until done.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CMP_W = (CNT_W > 16) ? CNT_W : 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        word_q, word_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               byte_ready_q, byte_ready_d;
  logic               mem_we_q, mem_we_d;
  logic               core_hold_q, core_hold_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               xfer_c;

  // byte_ready_q reflects the current state, so this is the handshake for this cycle
  assign xfer_c = byte_valid & byte_ready_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LEN_HI;
          word_count_d = '0;
          byte_cnt_d   = '0;
          len_d        = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          len_d   = {byte_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer_c) begin
          len_d      = {len_q[15:8], byte_data};
          byte_cnt_d = '0;
          if (len_d == 16'd0) begin
            state_d = S_DONE;
          end else if (32'(len_d) > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          word_d     = {word_q[23:0], byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_wdata_d = word_d;
            mem_addr_d  = word_count_q[ADDR_W-1:0];
            state_d     = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + CNT_W'(1);
        if (CMP_W'(word_count_d) == CMP_W'(len_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_LEN_HI;
          word_count_d = '0;
          byte_cnt_d   = '0;
          len_d        = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Moore outputs registered from the next state so they line up with the state
    byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
    mem_we_d     = (state_d == S_WRITE);
    core_hold_d  = (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      word_count_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      core_hold_q  <= core_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory that the MIPS core fetches from. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them to consecutive word addresses starting at 0. It holds the core stalled (core_hold) until the whole program has been written. Sits between a host byte source (UART/testbench) and the instruction memory write port.

Parameters:
ADDR_W, 8, word-address width of instruction memory (the PC is a word index)
MAX_WORDS, 256, largest accepted program length in words; must be <= 2**ADDR_W

Ports:
clock  input  1  system clock, all state changes on posedge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse that begins a load
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  instruction word to write
core_hold  output  1  1 = core must not advance PC / execute
done  output  1  load completed successfully (sticky)
error  output  1  length header exceeded MAX_WORDS (sticky)
word_count  output  ADDR_W+1  number of words written in the current load

Behaviour:
- Reset: state IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, error=0, word_count=0, length/byte counters=0. Reset mid-load aborts it: no further mem_we pulses.
- Byte transfer happens on a posedge where byte_valid & byte_ready are both 1. byte_ready depends only on state, never on byte_valid.
- States:
  IDLE: byte_ready=0. On start -> LEN_HI.
  LEN_HI: byte_ready=1. On transfer, latch len[15:8] -> LEN_LO.
  LEN_LO: byte_ready=1. On transfer, latch len[7:0]. If len==0 -> DONE. If len>MAX_WORDS -> ERR. Otherwise -> DATA.
  DATA: byte_ready=1. Transfers fill the word MSB first: byte 0 -> [31:24], byte 3 -> [7:0]. On the 4th transfer -> WRITE.
  WRITE: byte_ready=0. mem_we=1 for exactly this one cycle, with mem_addr=word_count[ADDR_W-1:0] and mem_wdata=the assembled word. On the posedge that ends the cycle, word_count increments. If the new count==len -> DONE, else -> DATA.
  DONE: done=1, core_hold=0, byte_ready=0. A start pulse clears done and word_count, sets core_hold=1 -> LEN_HI (reload).
  ERR: error=1, core_hold=1, byte_ready=0, no writes. A start pulse clears error and word_count -> LEN_HI.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- core_hold=1 in every state except DONE. It falls in the first cycle of DONE, so the core restarts fetching at PC=0.
- Write latency: mem_we is asserted in the cycle immediately after the 4th byte of a word transfers.
- Throughput: at most 4 bytes per 5 cycles.
- Gaps (byte_valid=0) in any receiving state simply stall; partial words are kept.
- len==MAX_WORDS is legal; the last write goes to address MAX_WORDS-1 and there is no address wrap.
- mem_addr and mem_wdata may hold stale values when mem_we=0.

Test Plan:
- Reset, start, bytes 00 02 | 20 08 00 05 | 00 00 00 08 with byte_valid held high -> writes 0x20080005@0 then 0x00000008@1, each mem_we exactly 1 cycle; done=1, core_hold=0, word_count=2.
- Header 00 00 -> DONE in the cycle after the second byte, no mem_we pulse, core_hold drops.
- With MAX_WORDS=256, header 01 01 (257) -> ERR, error=1, core_hold stays 1, byte_ready=0, no writes. A following start plus header 00 01 and 4 data bytes -> error clears, 1 word written, done=1.
- Random byte_valid gaps (e.g. 3 idle cycles between each byte) for 3 words -> identical memory contents and addresses 0,1,2; byte_ready=0 only in WRITE.
- Reset asserted after 2 of 4 data bytes -> no mem_we afterwards, all outputs at reset values. A fresh load then starts writing at address 0.
- start pulse while in DATA -> ignored, load completes normally. start in DONE -> done=0, core_hold=1, reload overwrites from address 0.
